// File: rtl/alu_share_ctrl.sv
// Shares one combinational 32-bit ALU between two requesters, one operation at a time.
// The ALU is driven in IDLE -> ISSUE -> DONE order, and the response is held until it is consumed.
module alu_share_ctrl #(
    parameter logic FIRST_PRIO = 1'b0,
    parameter logic SLTU_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [2:0]  r0_op,
    input  logic [31:0] r0_a,
    input  logic [31:0] r0_b,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [2:0]  r1_op,
    input  logic [31:0] r1_a,
    input  logic [31:0] r1_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_cin,
    output logic [1:0]  alu_sel,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    input  logic        alu_negative,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_neg,
    output logic        rsp_carry,
    output logic        rsp_ovf,
    output logic        rsp_err,
    output logic        busy
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_SLTU = 3'd3;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic        id_q, id_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d, neg_q, neg_d, carry_q, carry_d;
    logic        ovf_q, ovf_d, err_q, err_d;

    logic        can_grant;
    logic        grant_id;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= 3'd5) && !((op == OP_SLTU) && !SLTU_EN);
    endfunction

    // Returns {alu_sel, alu_cin}; SLTU reuses the subtractor and inverts its carry afterwards.
    function automatic logic [2:0] op_ctrl(input logic [2:0] op);
        case (op)
            3'd1:    return 3'b00_1;
            3'd2:    return 3'b01_1;
            3'd3:    return 3'b00_1;
            3'd4:    return 3'b10_0;
            3'd5:    return 3'b11_0;
            default: return 3'b00_0;
        endcase
    endfunction

    assign can_grant = (state_q == S_IDLE) && !rst && (r0_valid || r1_valid);
    // On a tie the requester that lost last time wins; otherwise the lone requester wins.
    assign grant_id  = (r0_valid && r1_valid) ? !last_grant_q : r1_valid;
    assign r0_ready  = can_grant && !grant_id;
    assign r1_ready  = can_grant && grant_id;

    assign req_op = grant_id ? r1_op : r0_op;
    assign req_a  = grant_id ? r1_a  : r0_a;
    assign req_b  = grant_id ? r1_b  : r0_b;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        result_d     = result_q;
        zero_d       = zero_q;
        neg_d        = neg_q;
        carry_d      = carry_q;
        ovf_d        = ovf_q;
        err_d        = err_q;
        alu_a        = '0;
        alu_b        = '0;
        alu_sel      = 2'b00;
        alu_cin      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (can_grant) begin
                    op_d         = req_op;
                    a_d          = req_a;
                    b_d          = req_b;
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    if (op_is_legal(req_op)) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d  = S_DONE;
                        result_d = '0;
                        zero_d   = 1'b0;
                        neg_d    = 1'b0;
                        carry_d  = 1'b0;
                        ovf_d    = 1'b0;
                        err_d    = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                alu_a              = a_q;
                alu_b              = b_q;
                {alu_sel, alu_cin} = op_ctrl(op_q);
                result_d = (op_q == OP_SLTU) ? {31'b0, !alu_carry} : alu_out;
                zero_d   = alu_zero;
                neg_d    = alu_negative;
                carry_d  = alu_carry;
                ovf_d    = alu_overflow;
                err_d    = 1'b0;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= !FIRST_PRIO;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            neg_q        <= 1'b0;
            carry_q      <= 1'b0;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            neg_q        <= neg_d;
            carry_q      <= carry_d;
            ovf_q        <= ovf_d;
            err_q        <= err_d;
        end
    end

    assign rsp_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_neg    = neg_q;
    assign rsp_carry  = carry_q;
    assign rsp_ovf    = ovf_q;
    assign rsp_err    = err_q;
endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Controller that shares the single 32-bit multi-cycle-datapath ALU between two requesters: the execute sequencer (requester 0) and the address/PC-update sequencer (requester 1).
- Arbitrates round-robin, accepts one operation at a time, and translates a 3-bit operation code into the ALU's sel/Cin controls.
- Drives the combinational ALU for one cycle, registers its result and flags, and returns them with a valid/ready response handshake.

Parameters:
- FIRST_PRIO, 0, requester that wins the first tie after reset (0 or 1).
- SLTU_EN, 1, 1 = op 3 (SLTU) legal; 0 = op 3 treated as illegal.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- r0_valid  in  1  requester 0 has an operation
- r0_ready  out  1  requester 0 operation accepted this cycle
- r0_op  in  3  requester 0 opcode
- r0_a, r0_b  in  32 each  requester 0 operands
- r1_valid, r1_ready, r1_op, r1_a, r1_b  same as requester 0, for requester 1
- alu_a, alu_b  out  32 each  ALU operands
- alu_cin  out  1  ALU Cin (1 = subtract)
- alu_sel  out  2  ALU function select
- alu_out  in  32  ALU result
- alu_zero, alu_negative, alu_carry, alu_overflow  in  1 each  ALU flags
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester the response belongs to
- rsp_result  out  32  final result
- rsp_zero, rsp_neg, rsp_carry, rsp_ovf  out  1 each  captured ALU flags
- rsp_err  out  1  illegal opcode
- busy  out  1  state != IDLE

Behaviour:
- Opcode map to {alu_sel, alu_cin}:
  - 0 ADD = 00,0
  - 1 SUB = 00,1
  - 2 SLT = 01,1
  - 3 SLTU = 00,1; result = {31'b0, ~alu_carry}
  - 4 OR = 10,0
  - 5 AND = 11,0
  - 6, 7 = illegal
- FSM states:
  - IDLE: grant logic active.
    - rN_ready = 1 only for the granted requester; at most one ready per cycle.
    - Acceptance is rN_valid & rN_ready. It latches op, a, b and id, and updates last_grant.
    - Legal op goes to ISSUE. Illegal op goes directly to DONE with rsp_err = 1, rsp_result = 0, all flags 0.
  - ISSUE (exactly 1 cycle): alu_a, alu_b, alu_sel and alu_cin are driven from the latched registers.
    - At the clock edge, alu_out and flags are captured into the rsp_* registers, with the SLTU post-processing applied. Next state is DONE.
  - DONE: rsp_valid = 1; rsp_* stay stable until rsp_valid & rsp_ready. On that handshake, the next state is IDLE.
- Arbitration:
  - Only one requester valid: it is granted.
  - Both valid: grant goes to the requester opposite last_grant.
  - last_grant resets to ~FIRST_PRIO.
  - A grant is combinational from the valids in IDLE. A requester must hold valid and data until ready.
- No new acceptance in ISSUE or DONE. Both readys are 0 there, and the response must drain before the next grant. This keeps throughput at 1 op per 3 cycles minimum.
- Latency: acceptance at edge N, ISSUE during cycle N+1, rsp_valid = 1 from cycle N+2. An illegal op gives rsp_valid from N+1.
- Outside ISSUE: alu_a = alu_b = 0, alu_sel = 00, alu_cin = 0 (keeps ALU inputs quiet).
- Reset (any state, including mid-ISSUE or DONE with a pending response):
  - Next state IDLE; the pending op and response are discarded.
  - Outputs 0: rsp_valid, rsp_result, all rsp flags, rsp_err, rsp_id, both readys, busy, and all alu_* outputs.
  - last_grant is reinitialised.
- rsp_ready asserted while rsp_valid = 0 is ignored.
- A requester dropping valid before being granted is legal; no state changes.

Test Plan:
- Reset then r0 ADD a = 7, b = 5 -> r0_ready in the first IDLE cycle; alu_sel = 00, alu_cin = 0 during ISSUE; rsp_valid two cycles after acceptance; rsp_result = 12, rsp_id = 0, rsp_zero = 0.
- r1 SUB a = 5, b = 5 -> rsp_result = 0, rsp_zero = 1, rsp_carry = 1. Then r1 SLTU a = 3, b = 5 -> rsp_result = 1. SLTU a = 5, b = 3 -> rsp_result = 0.
- r0 and r1 held valid continuously, four ops each -> grants alternate 0, 1, 0, 1… starting with FIRST_PRIO; never both readys high; every response carries the correct rsp_id.
- rsp_ready held low 5 cycles after rsp_valid -> rsp_* stable the whole time and no ready to either requester. Raising rsp_ready -> IDLE next cycle, new grant possible that cycle.
- r0 op = 6 -> no ISSUE cycle (alu_sel stays 00 and alu_cin stays 0); rsp_valid one cycle after acceptance with rsp_err = 1 and rsp_result = 0. Repeat with SLTU_EN = 0 and op 3 -> same.
- Assert rst during DONE and during ISSUE -> next cycle rsp_valid = 0, busy = 0, alu_* = 0, pending response lost; the first subsequent tie is granted to FIRST_PRIO.
